// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ
// requesters. Ports: req_* (issue side), rsp_* (return side), rf_* (RF port),
// stall_cnt (optional stall counter, built only with RF_READ_ARB_STALL_CNT_EN).
module rf_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int REG_BIT = 16,
  localparam int ID_W = $clog2(NUM_REG),
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_vld,
  output logic [NUM_REQ-1:0]      req_rdy,
  input  logic [NUM_REQ*ID_W-1:0] req_addr0,
  input  logic [NUM_REQ*ID_W-1:0] req_addr1,
  output logic [NUM_REQ-1:0]      rsp_vld,
  input  logic [NUM_REQ-1:0]      rsp_rdy,
  output logic [REG_BIT-1:0]      rsp_data0,
  output logic [REG_BIT-1:0]      rsp_data1,
  output logic                    rf_addr_vld,
  input  logic                    rf_addr_rdy,
  output logic [ID_W-1:0]         rf_addr0,
  output logic [ID_W-1:0]         rf_addr1,
  input  logic                    rf_data_vld,
  output logic                    rf_data_rdy,
  input  logic [REG_BIT-1:0]      rf_data0,
  input  logic [REG_BIT-1:0]      rf_data1,
  output logic [15:0]             stall_cnt
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          owner_vld_q, owner_vld_d;

  logic          win_vld;
  logic [PW-1:0] win_id;
  logic          accept;
  logic          consume;

  // Scan from ptr upward, wrapping explicitly so non-power-of-two
  // requester counts never index past NUM_REQ-1.
  always_comb begin
    int idx;
    win_vld  = 1'b0;
    win_id   = '0;
    rf_addr0 = '0;
    rf_addr1 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && req_vld[idx]) begin
        win_vld  = 1'b1;
        win_id   = PW'(idx);
        rf_addr0 = req_addr0[idx*ID_W +: ID_W];
        rf_addr1 = req_addr1[idx*ID_W +: ID_W];
      end
    end
  end

  assign rf_addr_vld = win_vld;
  assign accept      = win_vld && rf_addr_rdy;

  always_comb begin
    req_rdy = '0;
    rsp_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = accept && (win_id == PW'(i));
      rsp_vld[i] = rf_data_vld && owner_vld_q &&
                   (owner_q == PW'(i));
    end
  end

  // With no owner any stray data is sunk.
  assign rf_data_rdy = owner_vld_q ? rsp_rdy[owner_q] : 1'b1;
  assign consume     = rf_data_vld && rf_data_rdy && owner_vld_q;
  assign rsp_data0   = rf_data0;
  assign rsp_data1   = rf_data1;

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (accept) begin
      owner_d     = win_id;
      owner_vld_d = 1'b1;
      ptr_d       = (win_id == PW'(NUM_REQ-1)) ? '0
                                               : win_id + PW'(1);
    end else if (consume) begin
      owner_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
    end
  end

`ifdef RF_READ_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (win_vld && !accept && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: table of per-cycle vectors, hand sequences,
// and a response scoreboard fed by a small register-file port model.
module tb_rf_read_arbiter;
  localparam int N   = 4;
  localparam int IDW = 3;
  localparam int RB  = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [N*IDW-1:0] req_addr0, req_addr1;
  logic [RB-1:0] rsp_data0, rsp_data1, rf_data0, rf_data1;
  logic rf_addr_vld, rf_addr_rdy, rf_data_vld, rf_data_rdy;
  logic [IDW-1:0] rf_addr0, rf_addr1;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  rf_read_arbiter #(.NUM_REQ(N), .NUM_REG(8), .REG_BIT(RB)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rf_addr_vld(rf_addr_vld), .rf_addr_rdy(rf_addr_rdy),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1),
    .rf_data_vld(rf_data_vld), .rf_data_rdy(rf_data_rdy),
    .rf_data0(rf_data0), .rf_data1(rf_data1),
    .stall_cnt(stall_cnt)
  );

  logic [RB-1:0]  regs [8];
  logic [IDW-1:0] ta0 [N];
  logic [IDW-1:0] ta1 [N];

  // Register-file port: one-cycle read, holds data until taken.
  logic dv_q;
  logic [RB-1:0] d0_q, d1_q;
  logic rf_block;

  always @(posedge clk) begin
    if (rst) dv_q <= 1'b0;
    else if (rf_addr_vld && rf_addr_rdy) begin
      dv_q <= 1'b1;
      d0_q <= regs[rf_addr0];
      d1_q <= regs[rf_addr1];
    end else if (rf_data_rdy) dv_q <= 1'b0;
  end

  assign rf_addr_rdy = !rf_block && (!dv_q || rf_data_rdy);
  assign rf_data_vld = dv_q;
  assign rf_data0    = d0_q;
  assign rf_data1    = d1_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int id;
    logic [RB-1:0] d0;
    logic [RB-1:0] d1;
  } exp_t;

  exp_t q[$];
  int m_ptr = 0;
  logic [15:0] m_stall = '0;

  // Reference model of the arbiter, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ptr   = 0;
      m_stall = '0;
    end else begin
      int ew;
      logic exp_dr;
      logic [N-1:0] exp_rv, exp_rr;
      exp_t e;
      ew = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (ew < 0 && req_vld[idx]) ew = idx;
      end
      exp_dr = (q.size() > 0) ? rsp_rdy[q[0].id] : 1'b1;
      exp_rv = '0;
      if (dv_q && q.size() > 0) exp_rv[q[0].id] = 1'b1;
      exp_rr = '0;
      if (ew >= 0 && rf_addr_rdy) exp_rr[ew] = 1'b1;
      chk("mon_rsp_vld", 32'(rsp_vld), 32'(exp_rv));
      chk("mon_data_rdy", 32'(rf_data_rdy), 32'(exp_dr));
      if (exp_rv != 0) begin
        chk("sb_data0", 32'(rsp_data0), 32'(q[0].d0));
        chk("sb_data1", 32'(rsp_data1), 32'(q[0].d1));
      end
      chk("mon_addr_vld", 32'(rf_addr_vld), 32'(ew >= 0));
      chk("mon_addr0", 32'(rf_addr0),
          (ew >= 0) ? 32'(ta0[ew]) : 32'd0);
      chk("mon_addr1", 32'(rf_addr1),
          (ew >= 0) ? 32'(ta1[ew]) : 32'd0);
      chk("mon_req_rdy", 32'(req_rdy), 32'(exp_rr));
      chk("mon_stall", 32'(stall_cnt), 32'(m_stall));
      if (dv_q && q.size() > 0 && exp_dr) void'(q.pop_front());
      if (ew >= 0 && rf_addr_rdy) begin
        e.id = ew;
        e.d0 = regs[ta0[ew]];
        e.d1 = regs[ta1[ew]];
        q.push_back(e);
        m_ptr = (ew + 1) % N;
      end else if (ew >= 0) begin
`ifdef RF_READ_ARB_STALL_CNT_EN
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      end
    end
  end

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] rr;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
  } vec_t;

  vec_t tbl [10];

  task automatic step(string nm, logic [N-1:0] vld, logic [N-1:0] rr,
                      logic [N-1:0] erdy, logic [N-1:0] ersp);
    req_vld = vld;
    rsp_rdy = rr;
    @(negedge clk);
    chk({nm, "_req_rdy"}, 32'(req_rdy), 32'(erdy));
    chk({nm, "_rsp_vld"}, 32'(rsp_vld), 32'(ersp));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    req_vld = '0;
    rsp_rdy = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_stall;
    for (int i = 0; i < 8; i++) regs[i] = 16'hA000 + 16'(i);
    regs[3] = 16'h00AA;
    regs[5] = 16'h0055;
    for (int i = 0; i < N; i++) begin
      ta0[i] = IDW'(i + 1);
      ta1[i] = IDW'(i + 3);
      req_addr0[i*IDW +: IDW] = ta0[i];
      req_addr1[i*IDW +: IDW] = ta1[i];
    end
    tbl[0] = '{4'b0100, 4'b1111, 4'b0100, 4'b0000};
    tbl[1] = '{4'b0000, 4'b1111, 4'b0000, 4'b0100};
    tbl[2] = '{4'b1001, 4'b1111, 4'b1000, 4'b0000};
    tbl[3] = '{4'b1001, 4'b1111, 4'b0001, 4'b1000};
    tbl[4] = '{4'b1111, 4'b1111, 4'b0010, 4'b0001};
    tbl[5] = '{4'b1111, 4'b1111, 4'b0100, 4'b0010};
    tbl[6] = '{4'b1111, 4'b1111, 4'b1000, 4'b0100};
    tbl[7] = '{4'b1111, 4'b1111, 4'b0001, 4'b1000};
    tbl[8] = '{4'b0000, 4'b1111, 4'b0000, 4'b0001};
    tbl[9] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};

    rst = 1'b1;
    rf_block = 1'b0;
    req_vld = '0;
    rsp_rdy = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      step($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].rr,
           tbl[i].exp_rdy, tbl[i].exp_rsp);

    // Requester 1 owns the read and stalls its response 3 cycles.
    step("bp_grant", 4'b0010, 4'b1111, 4'b0010, 4'b0000);
    for (int i = 0; i < 3; i++)
      step("bp_hold", 4'b0001, 4'b1101, 4'b0000, 4'b0010);
    step("bp_release", 4'b0001, 4'b1111, 4'b0001, 4'b0010);
    step("bp_drain", 4'b0000, 4'b1111, 4'b0000, 4'b0001);

    // Reset while a response is held.
    step("rst_grant", 4'b0100, 4'b1111, 4'b0100, 4'b0000);
    step("rst_held", 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    pulse_rst();
    req_vld = '0;
    rsp_rdy = '1;
    @(negedge clk);
    chk("rst_mid_rsp", 32'(rsp_vld), 32'd0);
    chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    step("rst_ptr0", 4'b1111, 4'b1111, 4'b0001, 4'b0000);
    step("rst_after", 4'b0000, 4'b1111, 4'b0000, 4'b0001);

    // Address channel blocked for 5 cycles.
    pulse_rst();
    rf_block = 1'b1;
    for (int i = 0; i < 5; i++)
      step("stall", 4'b0001, 4'b1111, 4'b0000, 4'b0000);
    req_vld = '0;
    rsp_rdy = '1;
`ifdef RF_READ_ARB_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    @(negedge clk);
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    @(posedge clk);
    #1;
    rf_block = 1'b0;
    step("stall_grant", 4'b0001, 4'b1111, 4'b0001, 4'b0000);
    step("stall_rsp", 4'b0000, 4'b1111, 4'b0000, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
Shares one read port of the register file between NUM_REQ requesters, such as reservation-station issue slots. Each request carries two operand addresses. The block arbitrates round-robin, drives the port's address channel, and tracks which requester owns the outstanding read. It routes the returned data channel back to that requester only. It sits between the issue logic and one read port of the register file.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_REG, 8, registers in the file; REG_ID_BIT = $clog2(NUM_REG)
REG_BIT, 16, data width per register

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_vld  in  NUM_REQ  per-requester read request valid
req_rdy  out  NUM_REQ  per-requester request accepted
req_addr0  in  NUM_REQ*REG_ID_BIT  operand-0 address, requester i at [i*REG_ID_BIT+:REG_ID_BIT]
req_addr1  in  NUM_REQ*REG_ID_BIT  operand-1 address, same packing
rsp_vld  out  NUM_REQ  response valid, one-hot or zero
rsp_rdy  in  NUM_REQ  response ready per requester
rsp_data0  out  REG_BIT  operand-0 data, shared by all requesters
rsp_data1  out  REG_BIT  operand-1 data, shared by all requesters
rf_addr_vld  out  1  to register-file read address valid
rf_addr_rdy  in  1  from register-file read address ready
rf_addr0  out  REG_ID_BIT  to register file
rf_addr1  out  REG_ID_BIT  to register file
rf_data_vld  in  1  from register-file read data valid
rf_data_rdy  out  1  to register-file read data ready
rf_data0  in  REG_BIT  from register file
rf_data1  in  REG_BIT  from register file
stall_cnt  out  16  arbitration-stall counter (see Optional Feature)

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high. All state is cleared on the clk edge where rst=1.
- State:
  - ptr: round-robin pointer, $clog2(NUM_REQ) bits, reset 0.
  - owner: requester id of the outstanding read.
  - owner_vld: reset 0.
- Winner (combinational): first i with req_vld[i]=1, scanning ptr, ptr+1, ..., wrapping mod NUM_REQ. There is no winner if req_vld==0.
- Address channel:
  - rf_addr_vld = |req_vld.
  - rf_addr0/rf_addr1 = the winner's addresses, or 0 when there is no winner.
  - req_rdy[winner] = rf_addr_rdy. All other req_rdy bits are 0.
- Accept: rf_addr_vld && rf_addr_rdy. On accept:
  - owner <= winner; owner_vld <= 1.
  - ptr <= (winner+1) mod NUM_REQ.
  - ptr changes only on accept.
- Data channel:
  - rsp_vld[i] = rf_data_vld && owner_vld && owner==i.
  - rf_data_rdy = owner_vld ? rsp_rdy[owner] : 1.
  - rsp_data0/rsp_data1 pass rf_data0/rf_data1 through combinationally.
- Consume: rf_data_vld && rf_data_rdy && owner_vld. On consume without a same-cycle accept, owner_vld <= 0.
- Same-cycle consume and accept (back-to-back, which the port permits): owner <= new winner and owner_vld stays 1. Throughput is 1 read/cycle when rsp_rdy is held high.
- Latency: request accept to rsp_vld is 1 cycle, set by the register-file port. The arbiter adds no cycles.
- Response backpressure: if rsp_rdy[owner]=0, rsp_vld stays high and data is held by the port. rf_addr_rdy drops, so no new request is accepted.
- Stability: a requester holds req_vld and its addresses until req_rdy. The winner may change to a higher-priority newcomer before accept. That is legal.
- rf_data_vld with owner_vld=0 is a protocol error: the data is sunk and no rsp_vld is raised.
- Reset mid-operation: owner_vld is cleared and any in-flight response is dropped. The register-file port must be reset on the same edge.
- NUM_REQ not a power of two: the pointer wraps from NUM_REQ-1 to 0 explicitly.

Optional Feature:
Macro RF_READ_ARB_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 in each cycle where |req_vld=1 and no accept occurs. It saturates at 16'hFFFF and resets to 0.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.
- Arbitration behaviour is identical in both cases.

Test Plan:
- Single requester: req_vld=4'b0100, addr0=3, addr1=5, reg3=16'h00AA, reg5=16'h0055, rsp_rdy=1. Response: req_rdy[2] pulses, the next cycle rsp_vld=4'b0100 with data0=00AA, data1=0055, then ptr=3.
- All four requesters valid continuously with rsp_rdy=all 1s. Response: grants go 0,1,2,3,0,... on consecutive cycles, one response per cycle, and each rsp_vld matches the previous cycle's grant.
- Backpressure: requester 1 owns the read with rsp_rdy[1]=0 for 3 cycles while req 0 is valid. Response: rsp_vld[1] is held 3 cycles, req_rdy=0 throughout, and req 0 is accepted in the cycle rsp_rdy[1] rises.
- Priority wrap: ptr=3, req_vld=4'b1001. Response: req 3 wins first, then ptr=0 and req 0 wins.
- Reset mid-flight: assert rst while owner_vld=1 and rsp_rdy=0. Response: the next cycle all rsp_vld=0, ptr=0, and stall_cnt=0.
- With RF_READ_ARB_STALL_CNT_EN defined: hold req_vld=1 for 5 cycles with rf_addr_rdy=0. Response: stall_cnt=5. Without the macro, stall_cnt stays 0.
